// File: rtl/image_color_stat.sv
// rtl/image_color_stat.sv - per-image R/G/B accumulation, dominant channel pick and
// restoring-divider mean (8.FRAC_W) emitted as one record per image.
module image_color_stat #(
   parameter int CNT_W   = 16,
   parameter int FRAC_W  = 15,
   parameter int NUM_IMG = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [7:0]            pix_r,
   input  logic [7:0]            pix_g,
   input  logic [7:0]            pix_b,
   input  logic                  pix_last,
   input  logic [4:0]            img_index,
   output logic [1:0]            color,
   output logic [8+FRAC_W-1:0]   total,
   output logic [4:0]            index,
   output logic                  out_valid,
   output logic                  batch_done
);
   localparam int SUM_W  = 8 + CNT_W;
   localparam int TOT_W  = 8 + FRAC_W;
   localparam int DVD_W  = SUM_W + FRAC_W;
   localparam int IMG_W  = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;
   localparam int STEP_W = $clog2(TOT_W);
   localparam logic [CNT_W-1:0] CNT_FORCE = {{(CNT_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {ACC, CMP, DIV, OUT} state_t;

   state_t              state, state_nxt;
   logic [SUM_W-1:0]    sum_r, sum_g, sum_b;
   logic [CNT_W-1:0]    cnt;
   logic [4:0]          idx_q;
   logic [1:0]          col_q;
   logic [IMG_W-1:0]    img_cnt;
   logic [STEP_W-1:0]   step;
   logic [CNT_W-1:0]    rem;
   logic [TOT_W-1:0]    dvd;
   logic [TOT_W-1:0]    quo;

   logic                accept, last_px, div_done;
   logic [1:0]          dom;
   logic [SUM_W-1:0]    max_sum;
   logic [DVD_W-1:0]    dividend;
   logic [CNT_W:0]      trial, diff;
   logic                ge;
   logic [CNT_W-1:0]    rem_nxt;
   logic [TOT_W-1:0]    quo_nxt;

   assign accept   = pix_valid & pix_ready;
   // The pixel that brings cnt to its maximum closes the image regardless of pix_last.
   assign last_px  = pix_last | (cnt == CNT_FORCE);
   assign div_done = (step == STEP_W'(TOT_W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACC;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pix_ready = 1'b0;
      case (state)
         ACC: begin
            pix_ready = 1'b1;
            if (accept && last_px) state_nxt = CMP;
         end
         CMP: state_nxt = DIV;
         DIV: if (div_done) state_nxt = OUT;
         OUT: state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_comb begin
      dom     = 2'd0;
      max_sum = sum_r;
      if (sum_r == sum_g && sum_g == sum_b) begin
         dom = 2'd3;
      end else if (sum_r >= sum_g && sum_r >= sum_b) begin
         dom = 2'd0;
      end else if (sum_g >= sum_b) begin
         dom     = 2'd1;
         max_sum = sum_g;
      end else begin
         dom     = 2'd2;
         max_sum = sum_b;
      end
   end

   assign dividend = {max_sum, {FRAC_W{1'b0}}};

   // Quotient < 2**TOT_W, so the dividend bits above the low TOT_W start out below cnt.
   assign trial   = {rem, dvd[TOT_W-1]};
   assign diff    = trial - {1'b0, cnt};
   assign ge      = (trial >= {1'b0, cnt});
   assign rem_nxt = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
   assign quo_nxt = {quo[TOT_W-2:0], ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r      <= '0;
         sum_g      <= '0;
         sum_b      <= '0;
         cnt        <= '0;
         idx_q      <= '0;
         col_q      <= '0;
         img_cnt    <= '0;
         step       <= '0;
         rem        <= '0;
         dvd        <= '0;
         quo        <= '0;
         color      <= '0;
         total      <= '0;
         index      <= '0;
         out_valid  <= 1'b0;
         batch_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         batch_done <= 1'b0;
         case (state)
            ACC: if (accept) begin
               sum_r <= sum_r + SUM_W'(pix_r);
               sum_g <= sum_g + SUM_W'(pix_g);
               sum_b <= sum_b + SUM_W'(pix_b);
               cnt   <= cnt + CNT_W'(1);
               if (last_px) idx_q <= img_index;
            end
            CMP: begin
               col_q <= dom;
               rem   <= dividend[DVD_W-1:TOT_W];
               dvd   <= dividend[TOT_W-1:0];
               step  <= '0;
            end
            DIV: begin
               rem  <= rem_nxt;
               dvd  <= {dvd[TOT_W-2:0], 1'b0};
               quo  <= quo_nxt;
               step <= step + STEP_W'(1);
               if (div_done) begin
                  color      <= col_q;
                  total      <= quo_nxt;
                  index      <= idx_q;
                  out_valid  <= 1'b1;
                  batch_done <= (img_cnt == IMG_W'(NUM_IMG - 1));
                  img_cnt    <= (img_cnt == IMG_W'(NUM_IMG - 1)) ? '0 : img_cnt + IMG_W'(1);
               end
            end
            OUT: begin
               sum_r <= '0;
               sum_g <= '0;
               sum_b <= '0;
               cnt   <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_image_color_stat.sv
// tb/tb_image_color_stat.sv - scoreboard bench for image_color_stat.
module tb_image_color_stat;
   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid, pix_ready, pix_last;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic [4:0]  img_index;
   logic [1:0]  color;
   logic [22:0] total;
   logic [4:0]  index;
   logic        out_valid, batch_done;

   image_color_stat dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_last(pix_last),
      .img_index(img_index), .color(color), .total(total), .index(index),
      .out_valid(out_valid), .batch_done(batch_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [1:0]  c;
      logic [22:0] t;
      logic [4:0]  i;
      logic        bd;
      int          acc_cyc;
   } rec_t;
   rec_t sb[$];

   int tests = 0, fails = 0;
   longint ar = 0, ag = 0, ab = 0;
   int n = 0, img_m = 0, last_stalls = 0, bd_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_expected(input int idx, input int acc_cyc);
      rec_t r;
      longint mx;
      if (ar == ag && ag == ab) begin r.c = 2'd3; mx = ar; end
      else if (ar >= ag && ar >= ab) begin r.c = 2'd0; mx = ar; end
      else if (ag >= ab) begin r.c = 2'd1; mx = ag; end
      else begin r.c = 2'd2; mx = ab; end
      r.t = 23'((mx * 32768) / n);
      r.i = 5'(idx);
      r.bd = (img_m == 31);
      r.acc_cyc = acc_cyc;
      img_m = (img_m + 1) % 32;
      sb.push_back(r);
   endtask

   task automatic px(input int r, input int g, input int b, input bit last, input int idx, input bit push);
      bit rdy;
      int k;
      pix_r = 8'(r); pix_g = 8'(g); pix_b = 8'(b);
      pix_last = last; img_index = 5'(idx); pix_valid = 1'b1;
      last_stalls = 0; k = 0;
      do begin
         rdy = pix_ready;
         @(posedge clk); #1;
         if (!rdy) last_stalls++;
         k++;
      end while (!rdy && k < 100);
      if (!rdy) check("accept_timeout", 32'd0, 32'd1);
      pix_valid = 1'b0;
      pix_last  = 1'b0;
      ar += r; ag += g; ab += b; n++;
      if (last) begin
         if (push) push_expected(idx, cyc);
         ar = 0; ag = 0; ab = 0; n = 0;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sb.size() > 0 && k < 200) begin @(posedge clk); k++; end
      if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (batch_done) bd_seen++;
         if (sb.size() == 0) begin
            check("spurious_out_valid", 32'd1, 32'd0);
         end else begin
            rec_t e;
            e = sb.pop_front();
            check("color", color, e.c);
            check("total", total, e.t);
            check("index", index, e.i);
            check("batch_done", batch_done, e.bd);
            check("latency", cyc - e.acc_cyc, 24);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pix_valid = 1'b0; pix_last = 1'b0;
      pix_r = '0; pix_g = '0; pix_b = '0; img_index = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pix_ready", pix_ready, 1);
      check("rst_color", color, 0);
      check("rst_total", total, 0);
      check("rst_index", index, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_batch_done", batch_done, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      px(200, 10, 5, 1, 3, 1);
      wait_idle();
      check("hold_color", color, 0);
      check("hold_total", total, 6553600);

      for (int i = 0; i < 4; i++) px(0, 10 + i, 0, i == 3, 7, 1);
      for (int i = 0; i < 3; i++) px(50, 50, 50, i == 2, 1, 1);
      for (int i = 0; i < 3; i++) px(60, 60, 0, i == 2, 2, 1);
      px(0, 1, 0, 0, 4, 1); px(0, 1, 0, 0, 4, 1); px(0, 2, 0, 1, 4, 1);
      px(3, 4, 100, 0, 5, 1); px(7, 0, 101, 1, 5, 1);
      wait_idle();

      px(9, 0, 0, 1, 9, 1);
      px(1, 2, 250, 1, 10, 1);
      check("stall_cycles", last_stalls, 25);
      wait_idle();

      px(7, 7, 0, 0, 11, 0);
      px(100, 0, 0, 1, 6, 0);
      repeat (10) @(posedge clk);
      #1; rst = 1'b1; #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_total", total, 0);
      check("mid_rst_color", color, 0);
      check("mid_rst_index", index, 0);
      check("mid_rst_pix_ready", pix_ready, 1);
      @(posedge clk); #1; rst = 1'b0; img_m = 0;
      px(0, 0, 30, 1, 12, 1);
      wait_idle();

      img_m = 1;
      bd_seen = 0;
      for (int i = 0; i < 33; i++)
         px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1, (i + 1) % 32, 1);
      wait_idle();
      check("batch_done_pulses", bd_seen, 1);
      check("queue_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
